clause_scan_controller: RTL
===========================

Name: clause_scan_controller

Overview:
- Sequences one Boolean-constraint-propagation (BCP) pass over the clause memory.
- Fetches clauses 0..num_clause-1 in order and classifies each against the current assignment: satisfied, unit, conflicting or unresolved.
- Streams each implied literal to the implication queue over a valid/ready handshake.
- Sits between the solver's top-level decision FSM (which starts a pass), the clause RAM and assignment table (read side), and the implication queue (write side).

Parameters:
- VAR_PER_CLAUSE, 5, literal slots per clause
- NUM_CLAUSE, 1023, clause memory depth
- CLAUSE_INDEX, 9, MSB index of a clause address (10 bits)
- NUM_VARIABLE, 128, variables supported
- VARIABLE_INDEX, 6, MSB index of a variable ID (7 bits)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse; begins a pass (ignored unless idle)
- num_clause  in  10  clauses in this pass; sampled on start
- clause_rd_en  out  1  clause RAM / assignment table read strobe
- clause_addr  out  10  clause index being read
- clause_variable  in  5x7  variable ID per slot; valid one cycle after clause_rd_en
- clause_mask  in  5  slot in use
- clause_pole  in  5  1 = negated literal
- var_unassign  in  5  per-slot variable unassigned; same timing as clause data
- var_val  in  5  per-slot assigned value; same timing
- imp_valid  out  1  implication offered
- imp_ready  in  1  queue accepts
- imp_var  out  7  implied variable
- imp_val  out  1  value to assign (= ~pole of the unassigned slot)
- imp_clause  out  10  reason clause
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- conflict  out  1  last pass hit a conflict; held until next accepted start
- conflict_clause  out  10  first conflicting clause index
- imp_count  out  10  implications accepted in the current/last pass

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset mid-pass aborts the pass immediately: no done, counters cleared.
- Per-slot rules:
  - lit_true = mask & ~unassign & (val ^ pole)
  - open = mask & unassign
- Clause classification:
  - sat = |lit_true
  - unit = !sat & (popcount(open)==1)
  - conflict = !sat & (open==0) & (mask!=0)
  - An all-zero mask is treated as satisfied (padding).
- States:
  - IDLE: busy=0. On start, latch num_clause, clear imp_count and conflict, set idx=0. Go to DONE if num_clause==0, else FETCH.
  - FETCH: clause_rd_en=1, clause_addr=idx. Go to EVAL.
  - EVAL: data valid; classify.
    - conflict: set conflict, conflict_clause=idx; go to DONE (pass stops).
    - unit: load imp_var/imp_val/imp_clause from the single open slot; go to PUSH.
    - otherwise: go to NEXT.
  - PUSH: imp_valid=1; outputs held stable until imp_ready. On handshake, imp_count+1 and go to NEXT. imp_ready while not in PUSH is ignored.
  - NEXT (combinational advance, no extra cycle): idx+1. If idx+1==num_clause go to DONE, else FETCH.
  - DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- busy=1 in FETCH, EVAL and PUSH.
- Latency:
  - start at cycle t with N clauses and no implications: clause_rd_en at t+1, t+3, …; done at t+1+2N.
  - Each implication adds 1 cycle plus any imp_ready stall.
- start while busy is ignored.
- num_clause > NUM_CLAUSE is saturated to NUM_CLAUSE.
- No de-duplication: the same variable implied by two clauses is pushed twice; downstream resolves it.
- Assignments made by the queue during a pass are visible through var_unassign/var_val on later fetches; this block does not track them.

Decomposition:
- Package sat_pkg:
  - VAR_PER_CLAUSE, CLAUSE_INDEX, VARIABLE_INDEX constants
  - clause_t struct (variable, mask, pole)
  - scan_state_e enum {IDLE, FETCH, EVAL, PUSH, DONE}
- One combinational sub-module, clause_status_eval:
  - inputs: clause fields, var_unassign, var_val
  - outputs: sat, unit, conflict, unit_slot index
  - instantiated once; independently unit-testable.

Test Plan:
- num_clause=0, start → done at t+1; busy never 1; conflict=0; imp_count=0.
- 3 clauses all satisfied (slot0 mask=1, unassign=0, val=1, pole=0) → rd at addr 0,1,2; done at t+7; imp_valid never asserted.
- Clause 1 mask=5'b00011, slot0 false, slot1 open (var 42, pole=1), imp_ready=1 → one imp_valid with imp_var=42, imp_val=0, imp_clause=1; imp_count=1; done at t+8.
- Same unit clause with imp_ready held 0 for 4 cycles → imp_var/imp_val/imp_clause stable throughout; no further clause_rd_en until handshake; done delayed by 4 cycles.
- Clause 2 of 5 all masked slots false → conflict=1, conflict_clause=2, done; no reads of addr 3 or 4; conflict stays 1 until next start.
- Assert reset in PUSH mid-pass → all outputs 0 asynchronously; a subsequent start runs a clean pass from addr 0.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types and constants for the clause scan datapath.
package sat_pkg;

   localparam int VAR_PER_CLAUSE = 5;
   localparam int NUM_CLAUSE     = 1023;
   localparam int CLAUSE_INDEX   = 9;
   localparam int NUM_VARIABLE   = 128;
   localparam int VARIABLE_INDEX = 6;
   localparam int SLOT_INDEX     = 2;

   typedef logic [CLAUSE_INDEX:0]   clause_idx_t;
   typedef logic [VARIABLE_INDEX:0] var_id_t;
   typedef logic [SLOT_INDEX:0]     slot_idx_t;

   // One clause as it comes out of the clause RAM.
   typedef struct packed {
      var_id_t [VAR_PER_CLAUSE-1:0] variable;
      logic    [VAR_PER_CLAUSE-1:0] mask;
      logic    [VAR_PER_CLAUSE-1:0] pole;
   } clause_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EVAL,
      PUSH,
      DONE
   } scan_state_e;

   // Clamp a requested clause count to the memory depth.
   function automatic clause_idx_t saturate_count(input clause_idx_t n);
      if (32'(n) > NUM_CLAUSE) begin
         return clause_idx_t'(NUM_CLAUSE);
      end
      return n;
   endfunction

endpackage

// File: rtl/clause_status_eval.sv
// Combinational classifier: decides whether one clause is satisfied,
// unit, conflicting or unresolved under the current assignment.
module clause_status_eval
   import sat_pkg::*;
(
   input  logic [VAR_PER_CLAUSE-1:0] mask,
   input  logic [VAR_PER_CLAUSE-1:0] pole,
   input  logic [VAR_PER_CLAUSE-1:0] var_unassign,
   input  logic [VAR_PER_CLAUSE-1:0] var_val,
   output logic                      sat,
   output logic                      unit,
   output logic                      conflict,
   output slot_idx_t                 unit_slot
);

   logic [VAR_PER_CLAUSE-1:0] lit_true;
   logic [VAR_PER_CLAUSE-1:0] open;
   logic [2:0]                open_count;

   // Per-slot literal status, open-slot count and the position of the open slot;
   // an all-zero mask is padding and counts as satisfied.
   always_comb begin
      lit_true   = mask & ~var_unassign & (var_val ^ pole);
      open       = mask & var_unassign;
      open_count = '0;
      unit_slot  = '0;
      for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
         if (open[i]) begin
            open_count = open_count + 3'd1;
            unit_slot  = slot_idx_t'(i);
         end
      end
      sat      = (|lit_true) || (mask == '0);
      unit     = !sat && (open_count == 3'd1);
      conflict = !sat && (open == '0) && (mask != '0);
   end

endmodule

// File: rtl/clause_scan_controller.sv
// Runs one BCP pass over the clause memory: fetch, classify, and push
// each implied literal to the implication queue.
module clause_scan_controller
   import sat_pkg::*;
(
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic [CLAUSE_INDEX:0]                      num_clause,
   output logic                                       clause_rd_en,
   output logic [CLAUSE_INDEX:0]                      clause_addr,
   input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0] clause_variable,
   input  logic [VAR_PER_CLAUSE-1:0]                  clause_mask,
   input  logic [VAR_PER_CLAUSE-1:0]                  clause_pole,
   input  logic [VAR_PER_CLAUSE-1:0]                  var_unassign,
   input  logic [VAR_PER_CLAUSE-1:0]                  var_val,
   output logic                                       imp_valid,
   input  logic                                       imp_ready,
   output logic [VARIABLE_INDEX:0]                    imp_var,
   output logic                                       imp_val,
   output logic [CLAUSE_INDEX:0]                      imp_clause,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       conflict,
   output logic [CLAUSE_INDEX:0]                      conflict_clause,
   output logic [CLAUSE_INDEX:0]                      imp_count
);

   clause_t     clause_in;
   logic        eval_sat;
   logic        eval_unit;
   logic        eval_conflict;
   slot_idx_t   unit_slot;
   clause_idx_t next_idx;

   scan_state_e state_q, state_d;
   clause_idx_t idx_q, idx_d;
   clause_idx_t count_q, count_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        rd_en_q, rd_en_d;
   clause_idx_t addr_q, addr_d;
   logic        imp_valid_q, imp_valid_d;
   var_id_t     imp_var_q, imp_var_d;
   logic        imp_val_q, imp_val_d;
   clause_idx_t imp_clause_q, imp_clause_d;
   logic        conflict_q, conflict_d;
   clause_idx_t conflict_clause_q, conflict_clause_d;
   clause_idx_t imp_count_q, imp_count_d;

   assign clause_in = '{variable: clause_variable, mask: clause_mask, pole: clause_pole};

   clause_status_eval u_eval (
      .mask         (clause_in.mask),
      .pole         (clause_in.pole),
      .var_unassign (var_unassign),
      .var_val      (var_val),
      .sat          (eval_sat),
      .unit         (eval_unit),
      .conflict     (eval_conflict),
      .unit_slot    (unit_slot)
   );

   assign next_idx = idx_q + 10'd1;

   // Next-state and next-output computation; outputs are derived from the
   // next state so every output port comes straight from a flop.
   always_comb begin
      state_d           = state_q;
      idx_d             = idx_q;
      count_d           = count_q;
      addr_d            = addr_q;
      imp_var_d         = imp_var_q;
      imp_val_d         = imp_val_q;
      imp_clause_d      = imp_clause_q;
      conflict_d        = conflict_q;
      conflict_clause_d = conflict_clause_q;
      imp_count_d       = imp_count_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               count_d           = saturate_count(num_clause);
               imp_count_d       = '0;
               conflict_d        = 1'b0;
               conflict_clause_d = '0;
               idx_d             = '0;
               state_d           = (num_clause == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = EVAL;
         EVAL: begin
            if (eval_conflict) begin
               conflict_d        = 1'b1;
               conflict_clause_d = idx_q;
               state_d           = DONE;
            end else if (eval_unit) begin
               imp_var_d    = clause_in.variable[unit_slot];
               imp_val_d    = ~clause_in.pole[unit_slot];
               imp_clause_d = idx_q;
               state_d      = PUSH;
            end else begin
               idx_d   = next_idx;
               state_d = (next_idx == count_q) ? DONE : FETCH;
            end
         end
         PUSH: begin
            if (imp_ready) begin
               imp_count_d = imp_count_q + 10'd1;
               idx_d       = next_idx;
               state_d     = (next_idx == count_q) ? DONE : FETCH;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d      = (state_d == FETCH) || (state_d == EVAL) || (state_d == PUSH);
      rd_en_d     = (state_d == FETCH);
      done_d      = (state_d == DONE);
      imp_valid_d = (state_d == PUSH);
      if (state_d == FETCH) begin
         addr_d = idx_d;
      end
   end

   // Scan FSM state and its registered outputs; reset aborts any pass in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         idx_q             <= '0;
         count_q           <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         rd_en_q           <= 1'b0;
         addr_q            <= '0;
         imp_valid_q       <= 1'b0;
         imp_var_q         <= '0;
         imp_val_q         <= 1'b0;
         imp_clause_q      <= '0;
         conflict_q        <= 1'b0;
         conflict_clause_q <= '0;
         imp_count_q       <= '0;
      end else begin
         state_q           <= state_d;
         idx_q             <= idx_d;
         count_q           <= count_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         rd_en_q           <= rd_en_d;
         addr_q            <= addr_d;
         imp_valid_q       <= imp_valid_d;
         imp_var_q         <= imp_var_d;
         imp_val_q         <= imp_val_d;
         imp_clause_q      <= imp_clause_d;
         conflict_q        <= conflict_d;
         conflict_clause_q <= conflict_clause_d;
         imp_count_q       <= imp_count_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign clause_rd_en    = rd_en_q;
   assign clause_addr     = addr_q;
   assign imp_valid       = imp_valid_q;
   assign imp_var         = imp_var_q;
   assign imp_val         = imp_val_q;
   assign imp_clause      = imp_clause_q;
   assign conflict        = conflict_q;
   assign conflict_clause = conflict_clause_q;
   assign imp_count       = imp_count_q;

endmodule
